// File: rtl/vol_meter_pkg.sv
// Shared types and constants for the volume meter: FSM states, segment
// thresholds and the level-to-thermometer mapping.
package vol_meter_pkg;

    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned SEG_N   = 12;
    localparam int unsigned HOLD_W  = 4;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        PUBLISH = 2'd1,
        FROZEN  = 2'd2
    } vol_state_e;

    // Segment k lights once the level reaches THR[k]; upper segments are spaced wider.
    localparam logic [LEVEL_W-1:0] THR [SEG_N] = '{
        4'd0, 4'd1, 4'd2,  4'd3,  4'd4,  4'd5,
        4'd6, 4'd7, 4'd8, 4'd10, 4'd12, 4'd14
    };

    function automatic logic [SEG_N-1:0] level_to_mask(input logic [LEVEL_W-1:0] lvl);
        logic [SEG_N-1:0] m;
        m = '0;
        for (int k = 0; k < int'(SEG_N); k++) begin
            m[k] = (lvl >= THR[k]);
        end
        return m;
    endfunction

endpackage

// File: rtl/vol_peak_hold.sv
// Peak-hold register with decay: a new peak is held for HOLD_WINDOWS publishes,
// then drops by one level per publish until it meets the live level.
module vol_peak_hold
    import vol_meter_pkg::*;
#(
    parameter int unsigned HOLD_WINDOWS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               publish_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic [LEVEL_W-1:0] peak_level_o
);

    logic [LEVEL_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [LEVEL_W-1:0] peak_dec;

    assign peak_dec = peak_q - LEVEL_W'(1);

    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (publish_i) begin
            if (level_i >= peak_q) begin
                peak_d = level_i;
                hold_d = HOLD_W'(HOLD_WINDOWS);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                peak_d = (peak_dec > level_i) ? peak_dec : level_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign peak_level_o = peak_q;

endmodule

// File: rtl/volume_level_ctrl.sv
// Windowed loudness meter: tracks the max sample per window, publishes its top
// four bits as a level with a segment mask. Peak hold is built in with VOL_PEAK_HOLD_EN.
module volume_level_ctrl
    import vol_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W     = 10,
    parameter int unsigned WINDOW_LEN   = 2000,
    parameter int unsigned HOLD_WINDOWS = 4
) (
    input  logic                clk_sample,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] wave_sample,
    input  logic                freeze,
    output logic [LEVEL_W-1:0]  level,
    output logic                level_valid,
    output logic [LEVEL_W-1:0]  peak_level,
    output logic [SEG_N-1:0]    bar_mask
);

    localparam int unsigned CNT_W = $clog2(WINDOW_LEN + 1);

    if (WINDOW_LEN < 2 || WINDOW_LEN > 4095 || HOLD_WINDOWS > 15 || SAMPLE_W < LEVEL_W)
    begin : g_bad_cfg
        $error("volume_level_ctrl: illegal parameter set");
    end

    vol_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] win_max_q, win_max_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic                level_valid_q;
    logic [SEG_N-1:0]    bar_mask_q;
    logic                publish_c;

    // Window accumulation and state sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_max_d = win_max_q;
        publish_c = 1'b0;
        case (state_q)
            ACCUM: begin
                if (freeze) begin
                    state_d   = FROZEN;
                    cnt_d     = '0;
                    win_max_d = '0;
                end else if (sample_valid) begin
                    win_max_d = (wave_sample > win_max_q) ? wave_sample : win_max_q;
                    if (cnt_q == CNT_W'(WINDOW_LEN - 1)) begin
                        cnt_d   = CNT_W'(WINDOW_LEN);
                        state_d = PUBLISH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PUBLISH: begin
                publish_c = 1'b1;
                if (freeze) begin
                    state_d   = FROZEN;
                    cnt_d     = '0;
                    win_max_d = '0;
                end else begin
                    state_d = ACCUM;
                    // A sample landing here opens the next window.
                    if (sample_valid) begin
                        cnt_d     = CNT_W'(1);
                        win_max_d = wave_sample;
                    end else begin
                        cnt_d     = '0;
                        win_max_d = '0;
                    end
                end
            end
            FROZEN: begin
                cnt_d     = '0;
                win_max_d = '0;
                if (!freeze) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d   = ACCUM;
                cnt_d     = '0;
                win_max_d = '0;
            end
        endcase
    end

    assign level_d = publish_c ? win_max_q[SAMPLE_W-1 -: LEVEL_W] : level_q;

    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            cnt_q         <= '0;
            win_max_q     <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            bar_mask_q    <= SEG_N'(1);
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            win_max_q     <= win_max_d;
            level_q       <= level_d;
            level_valid_q <= publish_c;
            if (publish_c) begin
                bar_mask_q <= level_to_mask(level_d);
            end
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign bar_mask    = bar_mask_q;

`ifdef VOL_PEAK_HOLD_EN
    vol_peak_hold #(
        .HOLD_WINDOWS (HOLD_WINDOWS)
    ) u_peak_hold (
        .clk          (clk_sample),
        .rst_n        (rst_n),
        .publish_i    (publish_c),
        .level_i      (level_d),
        .peak_level_o (peak_level)
    );
`else
    assign peak_level = level_q;
`endif

endmodule

// File: doc/volume_level_ctrl.md
VOLUME_LEVEL_CTRL -- requirements
Module: volume_level_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 10, the width of the audio sample in bits.
REQ-002 SHALL have parameter WINDOW_LEN, default 2000, the number of valid samples per measurement window (legal range 2..4095).
REQ-003 SHALL have parameter HOLD_WINDOWS, default 4, the number of windows a new peak is held before it decays (legal range 0..15).
REQ-004 SHALL have port clk_sample  in  1  sample clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port sample_valid  in  1  qualifies wave_sample for the current cycle.
REQ-007 SHALL have port wave_sample  in  SAMPLE_W  unsigned microphone sample.
REQ-008 SHALL have port freeze  in  1  display freeze (the switch); stops measurement while high.
REQ-009 SHALL have port level  out  4  registered loudness level of the last completed window.
REQ-010 SHALL have port level_valid  out  1  one-cycle pulse when level is updated.
REQ-011 SHALL have port peak_level  out  4  registered peak-hold level.
REQ-012 SHALL have port bar_mask  out  12  thermometer mask of lit meter segments, derived from level.

Function
REQ-013 SHALL implement the FSM states ACCUM, PUBLISH and FROZEN.
REQ-014 SHALL, in ACCUM on each valid sample: set win_max to max(win_max, wave_sample) and increment the sample count.
REQ-015 SHALL move from ACCUM to PUBLISH on the valid sample that brings the count to WINDOW_LEN; that sample is included in the window.
REQ-016 SHALL, in PUBLISH (exactly one cycle), register level = win_max[SAMPLE_W-1 -: 4] and assert level_valid in the following cycle for one cycle only.
REQ-017 SHALL, on leaving PUBLISH, clear the count and win_max; a valid sample arriving during PUBLISH seeds the next window (count=1, win_max=that sample).
REQ-018 SHALL, from ACCUM with freeze high, enter FROZEN at the next edge and discard the partial window.
REQ-019 SHALL, when freeze rises during PUBLISH, complete the publish first and then enter FROZEN.
REQ-020 SHALL, in FROZEN, ignore samples and hold level, peak_level and bar_mask; level_valid SHALL stay low.
REQ-021 SHALL return from FROZEN to ACCUM with count=0 and win_max=0 one edge after freeze falls.
REQ-022 SHALL set bit k of bar_mask when level >= THR[k], where THR = {0,1,2,3,4,5,6,7,8,10,12,14}; bit 0 is therefore always set.
REQ-023 SHALL hold the count within ceil(log2(WINDOW_LEN+1)) bits so that it never wraps before PUBLISH.

Reset
REQ-024 SHALL, while rst_n is low, force the state to ACCUM, count=0, win_max=0, level=0, level_valid=0, peak_level=0 and hold counter=0.
REQ-025 SHALL, on reset mid-window or mid-PUBLISH, abandon the window with no level_valid pulse.

Configuration
REQ-026 SHALL compile peak hold in when VOL_PEAK_HOLD_EN is defined: on each publish, if new level >= peak_level then peak_level=level and hold=HOLD_WINDOWS; else if hold != 0 then hold decrements; else peak_level=max(peak_level-1, level).
REQ-027 SHALL, when VOL_PEAK_HOLD_EN is undefined, drive peak_level equal to level and synthesize no hold counter.

Structure
REQ-028 SHALL take the FSM state enum, the THR threshold array and the segment count 12 from shared package vol_meter_pkg.
REQ-029 SHALL place the peak-hold/decay logic in sub-module vol_peak_hold, instantiated only under VOL_PEAK_HOLD_EN.

Verification (WINDOW_LEN=4, HOLD_WINDOWS=2, VOL_PEAK_HOLD_EN defined)
REQ-030 SHALL cover: samples 100,900,300,50 -> level=14 (900>>6), one level_valid pulse, bar_mask=12'hFFF after the 4th sample plus 2 cycles.
REQ-031 SHALL cover: window max 1023 then windows of max 0 -> peak_level holds 15 for 2 windows, then reads 14,13,12 on successive publishes; level=0, bar_mask=12'h001.
REQ-032 SHALL cover: freeze high after 2 of 4 samples, with 10 samples driven while frozen -> no level_valid and outputs unchanged; after release, a full window of 4 samples is required before the next publish.
REQ-033 SHALL cover: a valid sample of 640 during PUBLISH -> it becomes the first sample of the next window, and the next publish occurs after 3 more valid samples.
REQ-034 SHALL cover: rst_n low for 1 cycle mid-window after level=9 -> level=0, peak_level=0, no level_valid, and the count restarts.
REQ-035 SHALL cover: sample_valid low for 5 cycles mid-window -> the count is unchanged and the publish is delayed by exactly 5 cycles.
